// File: rtl/ps2_kbd_decoder.sv
// PS/2 scan-code set 2 decoder: turns received bytes into make/break key events
// and queues them in a show-ahead FIFO behind a valid/ready port.
module ps2_kbd_decoder #(
    parameter  int DEPTH       = 8,
    parameter  int TIMEOUT_CYC = 2500000,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx_done_tick,
    input  logic [7:0]        rx_data,
    output logic              rx_en,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [7:0]        ev_code,
    output logic              ev_ext,
    output logic              ev_brk,
    output logic [ADDR_W:0]   ev_count,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              bat_ok_tick
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_BASE,
        S_EXT,
        S_BRK,
        S_EXTBRK,
        S_PAUSE
    } state_e;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } event_t;

    state_e             state_q, state_d;
    logic [2:0]         skip_q, skip_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               bat_q, bat_d;

    logic               push;
    event_t             push_ev;

    event_t             mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    event_t             head_q, head_d;
    logic               ovf_q, ovf_d;
    logic               full, pop, wr_en, drop, last_leaves;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_BASE;
            skip_q  <= '0;
            tmo_q   <= '0;
            bat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            bat_q   <= bat_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        tmo_d   = '0;
        if (rx_done_tick) begin
            unique case (state_q)
                S_BASE: begin
                    if (rx_data == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (rx_data == 8'hE1) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_d = S_EXTBRK;
                    end else if (rx_data != 8'hE0) begin
                        state_d = S_BASE;
                    end
                end
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = S_BASE;
                    end
                end
                default: state_d = S_BASE;
            endcase
        end else if (state_q != S_BASE) begin
            // An abandoned prefix must not swallow the next unrelated key.
            if (tmo_q == TMO_LAST) begin
                state_d = S_BASE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        push    = 1'b0;
        push_ev = '0;
        bat_d   = 1'b0;
        if (rx_done_tick) begin
            unique case (state_q)
                S_BASE: begin
                    unique case (rx_data)
                        8'hE0, 8'hF0, 8'hE1,
                        8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
                        8'hAA:   bat_d = 1'b1;
                        default: begin
                            push    = 1'b1;
                            push_ev = '{brk: 1'b0, ext: 1'b0, code: rx_data};
                        end
                    endcase
                end
                S_EXT, S_BRK, S_EXTBRK: begin
                    if (rx_data != 8'hF0 && rx_data != 8'hE0) begin
                        push    = 1'b1;
                        push_ev = '{brk: (state_q != S_EXT),
                                    ext: (state_q != S_BRK),
                                    code: rx_data};
                    end
                end
                S_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        push    = 1'b1;
                        push_ev = '{brk: 1'b0, ext: 1'b1, code: 8'hE1};
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- event FIFO ----------------
    always_comb begin
        full     = (count_q == COUNT_MAX);
        ev_valid = (count_q != '0);
        pop      = ev_valid & ev_ready;
        wr_en    = push & (~full | pop);
        drop     = push & full & ~pop;

        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);

        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !wr_en) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end

        // When nothing older remains, the new head is the entry being written
        // this cycle, which is not in the array yet.
        last_leaves = (count_q == '0) | ((count_q == (ADDR_W + 1)'(1)) & pop);
        head_d = head_q;
        if (count_d != '0) begin
            head_d = last_leaves ? push_ev : mem_q[rd_ptr_d];
        end

        ovf_d = (ovf_q & ~ovf_clr) | drop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            ovf_q    <= ovf_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only read
    // after being written, and the visible head comes from the reset head_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_ev;
        end
    end

    assign rx_en       = ~full;
    assign ev_count    = count_q;
    assign ev_code     = head_q.code;
    assign ev_ext      = head_q.ext;
    assign ev_brk      = head_q.brk;
    assign ovf         = ovf_q;
    assign bat_ok_tick = bat_q;

endmodule
